// File: rtl/urv_imem_wb_bridge.sv
// uRV instruction-fetch responder to pipelined Wishbone, one read in flight.
// Define URV_IMEM_PREFETCH_EN for a one-entry next-word prefetch buffer.
module urv_imem_wb_bridge #(
    parameter int g_wb_word_addr = 0,
    parameter int g_ack_timeout  = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] im_addr_i,
    input  logic        im_rd_i,
    output logic [31:0] im_data_o,
    output logic        im_valid_o,
    output logic [31:0] wb_adr_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_BACKOFF} state_t;

    localparam logic [15:0] TMO_LAST =
        16'((g_ack_timeout > 0) ? g_ack_timeout - 1 : 0);

    state_t      state_q, state_d;
    logic [29:0] cur_q, cur_d;
    logic [29:0] bus_q, bus_d;
    logic [31:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic [15:0] tmo_q, tmo_d;

    logic [29:0] tgt;
    logic        chg;
    logic        kept;
    logic        hit;
    logic        tmo_hit;
    logic        unused_addr_lsb;

`ifdef URV_IMEM_PREFETCH_EN
    logic [29:0] pf_addr_q, pf_addr_d;
    logic [31:0] pf_data_q, pf_data_d;
    logic        pf_ok_q, pf_ok_d;
    logic        is_pf_q, is_pf_d;
`endif

    assign unused_addr_lsb = &{1'b0, im_addr_i[1:0]};

    always_comb begin
        tgt     = im_rd_i ? im_addr_i[31:2] : cur_q;
        chg     = (tgt != cur_q);
        kept    = valid_q && !chg;
        hit     = (bus_q == tgt);
        tmo_hit = (g_ack_timeout > 0) && (tmo_q >= TMO_LAST);

        state_d = state_q;
        cur_d   = tgt;
        bus_d   = bus_q;
        data_d  = data_q;
        valid_d = kept;
        cyc_d   = cyc_q;
        stb_d   = stb_q;
        tmo_d   = tmo_q;
`ifdef URV_IMEM_PREFETCH_EN
        pf_addr_d = pf_addr_q;
        pf_data_d = pf_data_q;
        pf_ok_d   = pf_ok_q;
        // a prefetch stays speculative unless the fetch moves elsewhere
        is_pf_d   = is_pf_q && (hit || !chg);
`endif

        unique case (state_q)
            S_IDLE: begin
                if (!kept) begin
                    state_d = S_ISSUE;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    bus_d   = tgt;
`ifdef URV_IMEM_PREFETCH_EN
                    pf_ok_d = 1'b0;
                    is_pf_d = 1'b0;
                    if (pf_ok_q && (pf_addr_q == tgt)) begin
                        data_d  = pf_data_q;
                        valid_d = 1'b1;
                        bus_d   = tgt + 30'd1;
                        is_pf_d = 1'b1;
                    end
`endif
                end
            end
            S_ISSUE: begin
                if (!wb_stall_i) begin
                    state_d = S_WAIT;
                    stb_d   = 1'b0;
                    tmo_d   = 16'd1;
                end
            end
            S_WAIT: begin
                if (wb_ack_i) begin
                    state_d = S_IDLE;
                    cyc_d   = 1'b0;
                    if (hit) begin
                        data_d  = wb_dat_i;
                        valid_d = 1'b1;
`ifdef URV_IMEM_PREFETCH_EN
                        state_d = S_ISSUE;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        bus_d   = tgt + 30'd1;
                        is_pf_d = 1'b1;
                        pf_ok_d = 1'b0;
`endif
                    end
`ifdef URV_IMEM_PREFETCH_EN
                    else if (is_pf_d) begin
                        pf_addr_d = bus_q;
                        pf_data_d = wb_dat_i;
                        pf_ok_d   = 1'b1;
                    end
`endif
                    else if (!kept) begin
                        state_d = S_ISSUE;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        bus_d   = tgt;
                    end
                end else if (tmo_hit) begin
                    state_d = S_BACKOFF;
                    cyc_d   = 1'b0;
                end else if (g_ack_timeout > 0) begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_BACKOFF: begin
                state_d = S_ISSUE;
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            bus_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            tmo_q   <= '0;
`ifdef URV_IMEM_PREFETCH_EN
            pf_addr_q <= '0;
            pf_data_q <= '0;
            pf_ok_q   <= 1'b0;
            is_pf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            bus_q   <= bus_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cyc_q   <= cyc_d;
            stb_q   <= stb_d;
            tmo_q   <= tmo_d;
`ifdef URV_IMEM_PREFETCH_EN
            pf_addr_q <= pf_addr_d;
            pf_data_q <= pf_data_d;
            pf_ok_q   <= pf_ok_d;
            is_pf_q   <= is_pf_d;
`endif
        end
    end

    assign im_data_o  = data_q;
    assign im_valid_o = valid_q;
    assign wb_adr_o   = (g_wb_word_addr != 0) ? {2'b00, bus_q} : {bus_q, 2'b00};
    assign wb_cyc_o   = cyc_q;
    assign wb_stb_o   = stb_q;
    assign wb_we_o    = 1'b0;
    assign wb_sel_o   = 4'hf;

endmodule

// File: tb/tb_urv_imem_wb_bridge.sv
// Scoreboard bench for urv_imem_wb_bridge with a pipelined Wishbone slave model.
// Prefetch checks are built only when URV_IMEM_PREFETCH_EN is defined.
module tb_urv_imem_wb_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] im_addr = '0;
    logic        im_rd = 1'b0;
    logic [31:0] im_data;
    logic        im_valid;
    logic [31:0] wb_adr;
    logic        wb_cyc;
    logic        wb_stb;
    logic        wb_we;
    logic [3:0]  wb_sel;
    logic [31:0] wb_dat = '0;
    logic        wb_ack = 1'b0;
    logic        wb_stall = 1'b0;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    int stall_req = 0;
    bit never_ack = 1'b0;
    int force_cnt = 0;

    always #5 clk = ~clk;

    urv_imem_wb_bridge #(
        .g_wb_word_addr(0),
        .g_ack_timeout(8)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .im_addr_i(im_addr),
        .im_rd_i(im_rd),
        .im_data_o(im_data),
        .im_valid_o(im_valid),
        .wb_adr_o(wb_adr),
        .wb_cyc_o(wb_cyc),
        .wb_stb_o(wb_stb),
        .wb_we_o(wb_we),
        .wb_sel_o(wb_sel),
        .wb_dat_i(wb_dat),
        .wb_ack_i(wb_ack),
        .wb_stall_i(wb_stall)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h100) return 32'h0000AAAA;
        return a ^ 32'h13;
    endfunction

    // slave: acks one cycle after the strobe is accepted
    bit          pend = 1'b0;
    logic [31:0] pend_adr = '0;
    int          stall_used = 0;
    int          force_seen = 0;

    always begin
        @(posedge clk);
        #1;
        wb_ack   = 1'b0;
        wb_stall = 1'b0;
        if (force_seen != force_cnt) begin
            force_seen = force_cnt;
            wb_ack = 1'b1;
            wb_dat = 32'hDEADBEEF;
        end else if (pend && wb_cyc && !never_ack) begin
            wb_ack = 1'b1;
            wb_dat = mem_word(pend_adr);
            pend   = 1'b0;
        end
        if (!wb_cyc) pend = 1'b0;
        if (!wb_stb) stall_used = 0;
        else if (wb_cyc) begin
            if (stall_used < stall_req) begin
                wb_stall = 1'b1;
                stall_used++;
            end else begin
                pend     = 1'b1;
                pend_adr = wb_adr;
            end
        end
    end

    task automatic request(input logic [31:0] a);
        im_rd   = 1'b1;
        im_addr = a;
        exp_q.push_back(mem_word({a[31:2], 2'b00}));
        @(negedge clk);
        im_rd = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        logic [31:0] exp;
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (im_valid === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'h0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s: im_valid_o not seen in 40 cycles", name);
        end else if (im_data !== exp) begin
            errors++;
            $display("FAIL %s: im_data_o=%h want %h", name, im_data, exp);
        end
    endtask

    task automatic wait_idle();
        int quiet = 0;
        for (int i = 0; i < 60 && quiet < 2; i++) begin
            @(negedge clk);
            if (wb_cyc === 1'b0) quiet++;
            else quiet = 0;
        end
        checks++;
        if (quiet < 2) begin
            errors++;
            $display("FAIL bus_idle: wb_cyc_o=%b want 0", wb_cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        im_rd = 1'b1;
        im_addr = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (im_valid !== 1'b0 || im_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_im: valid=%b data=%h want 0/0", im_valid, im_data);
        end
        checks++;
        if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || wb_adr !== 32'h0) begin
            errors++;
            $display("FAIL reset_wb: cyc=%b stb=%b adr=%h want 0", wb_cyc, wb_stb, wb_adr);
        end
        checks++;
        if (wb_we !== 1'b0 || wb_sel !== 4'hf) begin
            errors++;
            $display("FAIL ties: we=%b sel=%h want 0/f", wb_we, wb_sel);
        end
    endtask

    task automatic test_first_fetch();
        rst = 1'b0;
        exp_q.push_back(32'h00000013);
        @(negedge clk);
        im_rd = 1'b0;
        checks++;
        if (wb_stb !== 1'b1 || wb_adr !== 32'h0) begin
            errors++;
            $display("FAIL first_stb: stb=%b adr=%h want 1/0", wb_stb, wb_adr);
        end
        @(negedge clk);
        checks++;
        if (im_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_early: valid=%b want 0", im_valid);
        end
        @(negedge clk);
        wait_valid("first_fetch");
    endtask

    task automatic test_branch();
        wait_idle();
        im_rd = 1'b1;
        im_addr = 32'h100;
        @(negedge clk);
        im_addr = 32'h200;
        exp_q.push_back(mem_word(32'h200));
        @(negedge clk);
        im_rd = 1'b0;
        @(negedge clk);
        checks++;
        if (wb_stb !== 1'b1 || wb_adr !== 32'h200 || im_valid !== 1'b0) begin
            errors++;
            $display("FAIL branch_reissue: stb=%b adr=%h valid=%b want 1/200/0",
                     wb_stb, wb_adr, im_valid);
        end
        wait_valid("branch");
    endtask

    task automatic test_stall();
        wait_idle();
        stall_req = 3;
        im_rd = 1'b1;
        im_addr = 32'h300;
        exp_q.push_back(mem_word(32'h300));
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            im_rd = 1'b0;
            checks++;
            if (wb_stb !== 1'b1 || wb_adr !== 32'h300) begin
                errors++;
                $display("FAIL stall_hold%0d: stb=%b adr=%h want 1/300", i, wb_stb, wb_adr);
            end
        end
        @(negedge clk);
        stall_req = 0;
        checks++;
        if (wb_stb !== 1'b0 || wb_cyc !== 1'b1 || im_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_wait: stb=%b cyc=%b valid=%b want 0/1/0",
                     wb_stb, wb_cyc, im_valid);
        end
        @(negedge clk);
        checks++;
        if (im_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_latency: valid=%b want 1", im_valid);
        end
        wait_valid("stall");
    endtask

    task automatic test_hold();
        wait_idle();
        request(32'h40);
        wait_valid("hold_fetch");
        wait_idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (im_valid !== 1'b1 || im_data !== 32'h53 || wb_cyc !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d: valid=%b data=%h cyc=%b want 1/00000053/0",
                         i, im_valid, im_data, wb_cyc);
            end
        end
    endtask

    task automatic test_timeout();
        wait_idle();
        never_ack = 1'b1;
        im_rd = 1'b1;
        im_addr = 32'h500;
        @(negedge clk);
        im_rd = 1'b0;
        checks++;
        if (wb_stb !== 1'b1 || wb_adr !== 32'h500) begin
            errors++;
            $display("FAIL tmo_stb: stb=%b adr=%h want 1/500", wb_stb, wb_adr);
        end
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if (wb_cyc !== 1'b1 || wb_stb !== 1'b0) begin
                errors++;
                $display("FAIL tmo_wait%0d: cyc=%b stb=%b want 1/0", c, wb_cyc, wb_stb);
            end
        end
        @(negedge clk);
        checks++;
        if (wb_cyc !== 1'b0 || im_valid !== 1'b0) begin
            errors++;
            $display("FAIL tmo_drop: cyc=%b valid=%b want 0/0", wb_cyc, im_valid);
        end
        @(negedge clk);
        never_ack = 1'b0;
        exp_q.push_back(mem_word(32'h500));
        checks++;
        if (wb_stb !== 1'b1 || wb_cyc !== 1'b1 || wb_adr !== 32'h500) begin
            errors++;
            $display("FAIL tmo_retry: cyc=%b stb=%b adr=%h want 1/1/500",
                     wb_cyc, wb_stb, wb_adr);
        end
        wait_valid("tmo_refetch");
    endtask

    task automatic test_reset_mid();
        wait_idle();
        never_ack = 1'b1;
        im_rd = 1'b1;
        im_addr = 32'h700;
        @(negedge clk);
        im_rd = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        force_cnt++;
        @(negedge clk);
        checks++;
        if (wb_cyc !== 1'b0 || wb_stb !== 1'b0 || im_valid !== 1'b0 || im_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid: cyc=%b stb=%b valid=%b data=%h want 0",
                     wb_cyc, wb_stb, im_valid, im_data);
        end
        rst = 1'b0;
        never_ack = 1'b0;
        exp_q.push_back(32'h00000013);
        @(negedge clk);
        checks++;
        if (im_valid !== 1'b0 || wb_stb !== 1'b1 || wb_adr !== 32'h0) begin
            errors++;
            $display("FAIL rst_stale_ack: valid=%b stb=%b adr=%h want 0/1/0",
                     im_valid, wb_stb, wb_adr);
        end
        wait_valid("rst_refetch");
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [5] = '{32'h1000, 32'h1004, 32'h1008, 32'h2000, 32'h2004};
        wait_idle();
        foreach (seq[i]) begin
            request(seq[i]);
            wait_valid("b2b");
        end
        wait_idle();
        im_rd = 1'b1;
        im_addr = 32'h3000;
        @(negedge clk);
        im_addr = 32'h3004;
        @(negedge clk);
        im_addr = 32'h3008;
        exp_q.push_back(mem_word(32'h3008));
        @(negedge clk);
        im_rd = 1'b0;
        wait_valid("burst_last");
    endtask

    task automatic test_prefetch();
        wait_idle();
        request(32'h0);
        wait_valid("pf_demand");
`ifdef URV_IMEM_PREFETCH_EN
        checks++;
        if (wb_stb !== 1'b1 || wb_adr !== 32'h4) begin
            errors++;
            $display("FAIL pf_issue: stb=%b adr=%h want 1/4", wb_stb, wb_adr);
        end
        wait_idle();
        im_rd = 1'b1;
        im_addr = 32'h4;
        exp_q.push_back(mem_word(32'h4));
        @(negedge clk);
        im_rd = 1'b0;
        checks++;
        if (im_valid !== 1'b1 || im_data !== exp_q[0]) begin
            errors++;
            $display("FAIL pf_hit: valid=%b data=%h want 1/%h", im_valid, im_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
        checks++;
        if (wb_stb !== 1'b1 || wb_adr !== 32'h8) begin
            errors++;
            $display("FAIL pf_next: stb=%b adr=%h want 1/8", wb_stb, wb_adr);
        end
        wait_idle();
        request(32'h80);
        checks++;
        if (wb_stb !== 1'b1 || wb_adr !== 32'h80) begin
            errors++;
            $display("FAIL pf_miss: stb=%b adr=%h want 1/80", wb_stb, wb_adr);
        end
        wait_valid("pf_miss_data");
`else
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (wb_cyc !== 1'b0) begin
                errors++;
                $display("FAIL no_spec%0d: cyc=%b want 0", i, wb_cyc);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_branch();
        test_stall();
        test_hold();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_prefetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
